// File: rtl/dcache_wb_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encodings, address field positions and a line word-merge helper.
package dcache_wb_pkg;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_WB    = 2'd1,
        DC_ALLOC = 2'd2
    } dc_state_e;

    localparam int OFF_LSB = 0;
    localparam int OFF_MSB = 1;
    localparam int IDX_LSB = 2;
    localparam int LINE_W  = 128;

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel,
                                                   input logic [31:0]       word);
        logic [LINE_W-1:0] res;
        res = line;
        res[{sel, 5'd0} +: 32] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_wb_array.sv
// Line storage for the data cache: valid/dirty (async cleared), tag and data.
// Single index port; a fill takes priority over a word write on the same line.
module dcache_array
    import dcache_wb_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_word_en,
    input  logic [1:0]         wr_word_sel,
    input  logic [31:0]        wr_word_data,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [LINE_W-1:0]  fill_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] line_d;

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        line_d  = data_q[idx];
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            line_d       = fill_data;
        end else if (wr_word_en) begin
            dirty_d[idx] = 1'b1;
            line_d       = put_word(data_q[idx], wr_word_sel, wr_word_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_en | wr_word_en) data_q[idx] <= line_d;
        if (fill_en)              tag_q[idx]  <= fill_tag;
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage
// and a 128-bit line-wide memory bus. Hits complete in the same cycle.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic              proc_stall,
    output logic [31:0]       proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic              mem_ready,
    input  logic [127:0]      mem_rdata
);

    localparam int TAG_W   = ADDR_W - 2 - INDEX_W;
    localparam int IDX_MSB = IDX_LSB + INDEX_W - 1;
    localparam int TAG_LSB = IDX_LSB + INDEX_W;

    dc_state_e state_q, state_d;

    logic [1:0]         off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               req, hit;
    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_data;
    logic               wr_word_en, fill_en;

    assign off = proc_addr[OFF_MSB:OFF_LSB];
    assign idx = proc_addr[IDX_MSB:IDX_LSB];
    assign tag = proc_addr[ADDR_W-1:TAG_LSB];
    assign req = proc_read | proc_write;
    assign hit = rd_valid & (rd_tag == tag);

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .idx          (idx),
        .rd_valid     (rd_valid),
        .rd_dirty     (rd_dirty),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_word_en   (wr_word_en),
        .wr_word_sel  (off),
        .wr_word_data (proc_wdata),
        .fill_en      (fill_en),
        .fill_tag     (tag),
        .fill_data    (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DC_IDLE;
        else     state_q <= state_d;
    end

    // Outputs are gated by rst so the bus and pipeline see idle while reset is held.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_word_en = 1'b0;
        fill_en    = 1'b0;
        if (!rst) begin
            case (state_q)
                DC_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (proc_write) wr_word_en = 1'b1;
                            else            proc_rdata = rd_data[{off, 5'd0} +: 32];
                        end else begin
                            proc_stall = 1'b1;
                            state_d    = (rd_valid & rd_dirty) ? DC_WB : DC_ALLOC;
                        end
                    end
                end
                DC_WB: begin
                    proc_stall = 1'b1;
                    mem_write  = 1'b1;
                    mem_addr   = {rd_tag, idx};
                    mem_wdata  = rd_data;
                    if (mem_ready) state_d = DC_ALLOC;
                end
                DC_ALLOC: begin
                    // The access retries as a hit in IDLE, which also sets dirty for stores.
                    proc_stall = 1'b1;
                    mem_read   = 1'b1;
                    mem_addr   = proc_addr[ADDR_W-1:2];
                    if (mem_ready) begin
                        fill_en = 1'b1;
                        state_d = DC_IDLE;
                    end
                end
                default: state_d = DC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: the memory side is driven cycle by cycle from
// each scenario task with fixed latencies, so every wait is a bounded tick.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dcache_wb dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        proc_read = 1'b1;
        proc_addr = 30'h10;
        #2;
        n_cmp++; if ({proc_stall, mem_read, mem_write} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl: got %b want 000", {proc_stall, mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL rst_maddr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 128'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (proc_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", proc_rdata); end
        tick();
        tick();
        rst = 1'b0;
        proc_read = 1'b0;
        #1;
        n_cmp++; if ({proc_stall, mem_read} !== 2'b00) begin n_bad++; $display("FAIL rst_idle: got %b want 00", {proc_stall, mem_read}); end
    endtask

    task automatic test_read_miss();
        proc_read = 1'b1;
        proc_addr = 30'h10;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL rm_stall0: got %b want 1", proc_stall); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rm_idle_mrd: got %b want 0", mem_read); end
        tick();
        #1;
        n_cmp++; if ({mem_read, mem_write, proc_stall} !== 3'b101) begin n_bad++; $display("FAIL rm_alloc: got %b want 101", {mem_read, mem_write, proc_stall}); end
        n_cmp++; if (mem_addr !== 28'h4) begin n_bad++; $display("FAIL rm_maddr: got %h want 4", mem_addr); end
        tick();
        #1;
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rm_hold: got %b want 1", mem_read); end
        tick();
        mem_ready = 1'b1;
        mem_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL rm_stall3: got %b want 1", proc_stall); end
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        n_cmp++; if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL rm_done_stall: got %b want 0", proc_stall); end
        n_cmp++; if (proc_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rm_rdata: got %h want deadbeef", proc_rdata); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rm_done_mrd: got %b want 0", mem_read); end
        tick();
    endtask

    task automatic test_write_hit();
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_addr  = 30'h11;
        proc_wdata = 32'h12345678;
        #1;
        n_cmp++; if ({proc_stall, mem_read, mem_write} !== 3'b000) begin n_bad++; $display("FAIL wh_ctl: got %b want 000", {proc_stall, mem_read, mem_write}); end
        tick();
        proc_write = 1'b0;
        proc_read  = 1'b1;
        #1;
        n_cmp++; if (proc_rdata !== 32'h12345678) begin n_bad++; $display("FAIL wh_read: got %h want 12345678", proc_rdata); end
        n_cmp++; if ({proc_stall, mem_read, mem_write} !== 3'b000) begin n_bad++; $display("FAIL wh_rd_ctl: got %b want 000", {proc_stall, mem_read, mem_write}); end
        tick();
        proc_addr = 30'h10;
        #1;
        n_cmp++; if (proc_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wh_other: got %h want deadbeef", proc_rdata); end
        tick();
    endtask

    task automatic test_writeback();
        proc_read = 1'b1;
        proc_addr = 30'h31;
        #1;
        n_cmp++; if ({proc_stall, mem_write} !== 2'b10) begin n_bad++; $display("FAIL wb_miss: got %b want 10", {proc_stall, mem_write}); end
        tick();
        #1;
        n_cmp++; if ({mem_write, mem_read, proc_stall} !== 3'b101) begin n_bad++; $display("FAIL wb_ctl: got %b want 101", {mem_write, mem_read, proc_stall}); end
        n_cmp++; if (mem_addr !== 28'h4) begin n_bad++; $display("FAIL wb_maddr: got %h want 4", mem_addr); end
        n_cmp++; if (mem_wdata !== {32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wb_wdata: got %h want 33333333222222221234567 8deadbeef", mem_wdata); end
        mem_ready = 1'b1;
        tick();
        mem_rdata = {32'hCAFE0033, 32'hCAFE0032, 32'hCAFE0031, 32'hCAFE0030};
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL wb_alloc: got %b want 10", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 28'hC) begin n_bad++; $display("FAIL wb_alloc_addr: got %h want c", mem_addr); end
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++; if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL wb_done_stall: got %b want 0", proc_stall); end
        n_cmp++; if (proc_rdata !== 32'hCAFE0031) begin n_bad++; $display("FAIL wb_rdata: got %h want cafe0031", proc_rdata); end
        tick();
    endtask

    task automatic test_write_alloc();
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_addr  = 30'h08;
        proc_wdata = 32'hA5A5A5A5;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL wa_stall: got %b want 1", proc_stall); end
        tick();
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL wa_alloc_only: got %b want 10", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 28'h2) begin n_bad++; $display("FAIL wa_maddr: got %h want 2", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++; if ({proc_stall, mem_read} !== 2'b00) begin n_bad++; $display("FAIL wa_hit: got %b want 00", {proc_stall, mem_read}); end
        tick();
        proc_write = 1'b0;
        proc_read  = 1'b1;
        #1;
        n_cmp++; if (proc_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL wa_word: got %h want a5a5a5a5", proc_rdata); end
        tick();
        proc_addr = 30'h09;
        #1;
        n_cmp++; if (proc_rdata !== 32'h44440001) begin n_bad++; $display("FAIL wa_neighbor: got %h want 44440001", proc_rdata); end
        tick();
        proc_addr = 30'h28;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL wa_conf_stall: got %b want 1", proc_stall); end
        tick();
        #1;
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL wa_wb: got %b want 1", mem_write); end
        n_cmp++; if (mem_addr !== 28'h2) begin n_bad++; $display("FAIL wa_wb_addr: got %h want 2", mem_addr); end
        n_cmp++; if (mem_wdata !== {32'h44440003, 32'h44440002, 32'h44440001, 32'hA5A5A5A5}) begin n_bad++; $display("FAIL wa_wb_data: got %h", mem_wdata); end
        mem_ready = 1'b1;
        tick();
        mem_rdata = {32'h28280003, 32'h28280002, 32'h28280001, 32'h28280000};
        #1;
        n_cmp++; if (mem_addr !== 28'hA) begin n_bad++; $display("FAIL wa_alloc2_addr: got %h want a", mem_addr); end
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++; if (proc_rdata !== 32'h28280000) begin n_bad++; $display("FAIL wa_conf_rdata: got %h want 28280000", proc_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        proc_read = 1'b1;
        proc_addr = 30'h31;
        #1;
        n_cmp++; if ({proc_stall, proc_rdata} !== {1'b0, 32'hCAFE0031}) begin n_bad++; $display("FAIL rmid_prehit: got %b/%h want 0/cafe0031", proc_stall, proc_rdata); end
        tick();
        proc_addr = 30'h14;
        #1;
        tick();
        #1;
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rmid_alloc: got %b want 1", mem_read); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({mem_read, mem_write, proc_stall} !== 3'b000) begin n_bad++; $display("FAIL rmid_ctl: got %b want 000", {mem_read, mem_write, proc_stall}); end
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
        tick();
        rst = 1'b0;
        proc_addr = 30'h31;
        #1;
        n_cmp++; if ({proc_stall, mem_read} !== 2'b10) begin n_bad++; $display("FAIL rmid_remiss: got %b want 10", {proc_stall, mem_read}); end
        tick();
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL rmid_nowb: got %b want 10", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 28'hC) begin n_bad++; $display("FAIL rmid_maddr: got %h want c", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = {32'hCAFE0033, 32'hCAFE0032, 32'hCAFE0031, 32'hCAFE0030};
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++; if (proc_rdata !== 32'hCAFE0031) begin n_bad++; $display("FAIL rmid_refill: got %h want cafe0031", proc_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] line;
        proc_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            proc_addr = 30'(i * 4);
            #1;
            n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_fill_stall[%0d]: got %b want 1", i, proc_stall); end
            tick();
            #1;
            n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL b2b_fill_ctl[%0d]: got %b want 10", i, {mem_read, mem_write}); end
            for (int w = 0; w < 4; w++) line[w*32 +: 32] = 32'h10000000 | 32'(i << 8) | 32'(w);
            mem_ready = 1'b1;
            mem_rdata = line;
            tick();
            mem_ready = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            proc_addr = 30'((i * 4) + (i % 4));
            mem_ready = 1'(i % 2);
            mem_rdata = '1;
            #1;
            n_cmp++; if ({proc_stall, mem_read, mem_write} !== 3'b000) begin n_bad++; $display("FAIL b2b_ctl[%0d]: got %b want 000", i, {proc_stall, mem_read, mem_write}); end
            n_cmp++; if (proc_rdata !== (32'h10000000 | 32'(i << 8) | 32'(i % 4))) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h", i, proc_rdata); end
            tick();
        end
        mem_ready = 1'b0;
        proc_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_writeback();
        test_write_alloc();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
